// File: rtl/rf_dump_pkg.sv
// ---------------------------------------------------------------------------
// rf_dump_pkg
// Shared definitions for the register-file dump reader: default data and
// address widths and the state encoding of the dump controller.
// Optional feature macro used by this slice: RF_DUMP_CSUM_EN (adds an XOR
// checksum beat after the last data beat of every dump).
// ---------------------------------------------------------------------------
package rf_dump_pkg;

    localparam int DEF_DWIDTH = 32;
    localparam int DEF_AWIDTH = 5;

    // Dump controller states; CSUM is only reachable with RF_DUMP_CSUM_EN.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        SEND = 3'd2,
        CSUM = 3'd3,
        FIN  = 3'd4
    } state_e;

endpackage

// File: rtl/rf_dump_csum.sv
// ---------------------------------------------------------------------------
// rf_dump_csum
// XOR accumulator for the dump checksum. Only instantiated when the
// RF_DUMP_CSUM_EN macro is defined.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset (accumulator -> 0)
//   clear_i  in   synchronous clear (new dump accepted); wins over enable_i
//   enable_i in   fold data_i into the accumulator this cycle
//   data_i   in   DWIDTH word to accumulate
//   csum_o   out  current accumulator value
// ---------------------------------------------------------------------------
module rf_dump_csum #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              enable_i,
    input  logic [DWIDTH-1:0] data_i,
    output logic [DWIDTH-1:0] csum_o
);

    logic [DWIDTH-1:0] acc_q;

    // Running XOR of every word sampled during a dump; a new dump restarts
    // from zero so the checksum always covers exactly one window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clear_i) begin
            acc_q <= '0;
        end else if (enable_i) begin
            acc_q <= acc_q ^ data_i;
        end
    end

    assign csum_o = acc_q;

endmodule

// File: rtl/rf_dump_reader.sv
// ---------------------------------------------------------------------------
// rf_dump_reader
// Walks a window of registers through the register file's spare asynchronous
// read port and streams each word out on a valid/ready interface, for debug
// dumps to a host link.
// Optional feature: RF_DUMP_CSUM_EN appends one checksum beat (XOR of all
// data words) after the data beats; without it dout_csum is tied to 0.
// Ports:
//   clk, rst      clock / asynchronous active-high reset
//   start         1-cycle dump request, honoured only in IDLE
//   abort         synchronous cancel of a running dump
//   first_addr    first register of the window (sampled with start)
//   count         number of words, 0 means 2**AWIDTH (sampled with start)
//   ra / rd       register file read address / combinational read data
//   dout          stream data
//   dout_addr     register address of the current beat (0 on checksum beat)
//   dout_csum     current beat is the checksum beat
//   dout_last     current beat is the final beat of the dump
//   dout_valid    beat valid; dout_ready accepts it at posedge
//   busy          high from accepted start until return to IDLE
//   done          1-cycle pulse after the final beat was accepted
// ---------------------------------------------------------------------------
module rf_dump_reader
    import rf_dump_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int AWIDTH = DEF_AWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [AWIDTH-1:0] first_addr,
    input  logic [AWIDTH-1:0] count,
    output logic [AWIDTH-1:0] ra,
    input  logic [DWIDTH-1:0] rd,
    output logic [DWIDTH-1:0] dout,
    output logic [AWIDTH-1:0] dout_addr,
    output logic              dout_csum,
    output logic              dout_last,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done
);

    // Remaining-word counter needs one extra bit to hold 2**AWIDTH.
    localparam logic [AWIDTH:0] REM_ONE  = (AWIDTH+1)'(1);
    localparam logic [AWIDTH:0] REM_FULL = {1'b1, {AWIDTH{1'b0}}};

`ifdef RF_DUMP_CSUM_EN
    localparam bit LAST_ON_DATA = 1'b0;
`else
    localparam bit LAST_ON_DATA = 1'b1;
`endif

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] ra_q, ra_d;
    logic [AWIDTH:0]   remaining_q, remaining_d;
    logic [DWIDTH-1:0] dout_q, dout_d;
    logic [AWIDTH-1:0] dout_addr_q, dout_addr_d;
    logic              dout_last_q, dout_last_d;
    logic              dout_valid_q, dout_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

`ifdef RF_DUMP_CSUM_EN
    logic              dout_csum_q, dout_csum_d;
    logic              csumClear, csumEnable;
    logic [DWIDTH-1:0] csumValue;

    rf_dump_csum #(
        .DWIDTH(DWIDTH)
    ) uCsum (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (csumClear),
        .enable_i (csumEnable),
        .data_i   (rd),
        .csum_o   (csumValue)
    );
`endif

    // State and output registers. Every output is registered, so a reset
    // drives all of them to zero immediately and drops any in-flight beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ra_q         <= '0;
            remaining_q  <= '0;
            dout_q       <= '0;
            dout_addr_q  <= '0;
            dout_last_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef RF_DUMP_CSUM_EN
            dout_csum_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ra_q         <= ra_d;
            remaining_q  <= remaining_d;
            dout_q       <= dout_d;
            dout_addr_q  <= dout_addr_d;
            dout_last_q  <= dout_last_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef RF_DUMP_CSUM_EN
            dout_csum_q  <= dout_csum_d;
`endif
        end
    end

    // Next-state logic. Abort overrides everything outside IDLE. READ
    // captures the asynchronous read data for the current address into the
    // output register; SEND holds the beat until the sink accepts it, then
    // either advances the address or finishes the window.
    always_comb begin
        state_d      = state_q;
        ra_d         = ra_q;
        remaining_d  = remaining_q;
        dout_d       = dout_q;
        dout_addr_d  = dout_addr_q;
        dout_last_d  = dout_last_q;
        dout_valid_d = dout_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
`ifdef RF_DUMP_CSUM_EN
        dout_csum_d  = dout_csum_q;
        csumClear    = 1'b0;
        csumEnable   = 1'b0;
`endif

        if (abort && (state_q != IDLE)) begin
            state_d      = IDLE;
            dout_valid_d = 1'b0;
            dout_last_d  = 1'b0;
            busy_d       = 1'b0;
`ifdef RF_DUMP_CSUM_EN
            dout_csum_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        ra_d        = first_addr;
                        remaining_d = (count == '0) ? REM_FULL : {1'b0, count};
                        busy_d      = 1'b1;
                        state_d     = READ;
`ifdef RF_DUMP_CSUM_EN
                        csumClear   = 1'b1;
`endif
                    end
                end
                READ: begin
                    dout_d       = rd;
                    dout_addr_d  = ra_q;
                    dout_last_d  = LAST_ON_DATA && (remaining_q == REM_ONE);
                    dout_valid_d = 1'b1;
                    state_d      = SEND;
`ifdef RF_DUMP_CSUM_EN
                    csumEnable   = 1'b1;
`endif
                end
                SEND: begin
                    if (dout_ready) begin
                        dout_valid_d = 1'b0;
                        dout_last_d  = 1'b0;
                        remaining_d  = remaining_q - REM_ONE;
                        if (remaining_q > REM_ONE) begin
                            ra_d    = ra_q + 1'b1;
                            state_d = READ;
                        end else begin
`ifdef RF_DUMP_CSUM_EN
                            // Accumulator already includes the word just sent.
                            dout_d       = csumValue;
                            dout_addr_d  = '0;
                            dout_csum_d  = 1'b1;
                            dout_last_d  = 1'b1;
                            dout_valid_d = 1'b1;
                            state_d      = CSUM;
`else
                            state_d      = FIN;
`endif
                        end
                    end
                end
`ifdef RF_DUMP_CSUM_EN
                CSUM: begin
                    if (dout_ready) begin
                        dout_valid_d = 1'b0;
                        dout_last_d  = 1'b0;
                        dout_csum_d  = 1'b0;
                        state_d      = FIN;
                    end
                end
`endif
                FIN: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign ra         = ra_q;
    assign dout       = dout_q;
    assign dout_addr  = dout_addr_q;
    assign dout_last  = dout_last_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef RF_DUMP_CSUM_EN
    assign dout_csum  = dout_csum_q;
`else
    assign dout_csum  = 1'b0;
`endif

endmodule

// File: tb/tb_rf_dump_reader.sv
// ---------------------------------------------------------------------------
// tb_rf_dump_reader
// Scoreboard bench for rf_dump_reader: expected beats are queued when a dump
// is requested, and a forked monitor pops and compares every accepted beat.
// The register file is modelled as 32 words with R[i] = i * 0x11111111.
// ---------------------------------------------------------------------------
module tb_rf_dump_reader;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        csum;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [4:0]  first_addr;
    logic [4:0]  count;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic [31:0] dout;
    logic [4:0]  dout_addr;
    logic        dout_csum;
    logic        dout_last;
    logic        dout_valid;
    logic        dout_ready;
    logic        busy;
    logic        done;

    logic [31:0] rf [32];

    beat_t expQ[$];
    int    beatCyc[$];
    int    vectors;
    int    miscompares;
    int    doneCount;
    int    doneCyc;
    int    startCyc;
    int    cyc;
    beat_t held;
    bit    holdValid;

    rf_dump_reader #(
        .DWIDTH(32),
        .AWIDTH(5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .first_addr (first_addr),
        .count      (count),
        .ra         (ra),
        .rd         (rd),
        .dout       (dout),
        .dout_addr  (dout_addr),
        .dout_csum  (dout_csum),
        .dout_last  (dout_last),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done)
    );

    // Asynchronous register file read port.
    assign rd = rf[ra];

    // Free-running clock and cycle counter used for latency checks.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: at each negedge, a valid beat with ready high will be accepted
    // at the next posedge, so it is popped and compared here. A stalled beat is
    // remembered so the next cycle can confirm it was held stable.
    task automatic monitorLoop();
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                holdValid = 1'b0;
            end else begin
                if (dout_valid) begin
                    if (holdValid) begin
                        checkOutput("stall_data", dout, held.data);
                        checkOutput("stall_addr", dout_addr, held.addr);
                    end
                    if (dout_ready) begin
                        holdValid = 1'b0;
                        beatCyc.push_back(cyc);
                        if (expQ.size() == 0) begin
                            checkOutput("unexpected_beat", 1, 0);
                        end else begin
                            e = expQ.pop_front();
                            checkOutput("beat_data", dout, e.data);
                            checkOutput("beat_addr", dout_addr, e.addr);
                            checkOutput("beat_csum", dout_csum, e.csum);
                            checkOutput("beat_last", dout_last, e.last);
                        end
                    end else begin
                        held.data = dout;
                        held.addr = dout_addr;
                        holdValid = 1'b1;
                    end
                end else begin
                    holdValid = 1'b0;
                end
                if (done) begin
                    doneCount++;
                    doneCyc = cyc;
                end
            end
        end
    endtask

    // Queue the expected beats for a window and pulse start for one cycle.
    task automatic applyStimulus(input logic [4:0] first, input logic [4:0] cnt);
        beat_t b;
        logic [4:0]  a;
        logic [31:0] x;
        int n;
        n = (cnt == 5'd0) ? 32 : int'(cnt);
        a = first;
        x = 32'h0;
        for (int i = 0; i < n; i++) begin
            b.data = 32'h11111111 * {27'd0, a};
            b.addr = a;
            b.csum = 1'b0;
`ifdef RF_DUMP_CSUM_EN
            b.last = 1'b0;
`else
            b.last = (i == n - 1);
`endif
            x = x ^ b.data;
            expQ.push_back(b);
            a = a + 5'd1;
        end
`ifdef RF_DUMP_CSUM_EN
        b.data = x;
        b.addr = 5'd0;
        b.csum = 1'b1;
        b.last = 1'b1;
        expQ.push_back(b);
`endif
        @(posedge clk);
        #1;
        beatCyc.delete();
        startCyc   = cyc;
        start      = 1'b1;
        first_addr = first;
        count      = cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Run a whole dump to its done pulse, optionally stalling the sink.
    task automatic runDump(input logic [4:0] first, input logic [4:0] cnt,
                           input bit stall);
        int prevDone;
        int k;
        prevDone = doneCount;
        applyStimulus(first, cnt);
        k = 0;
        while (doneCount == prevDone && k < 3000) begin
            @(posedge clk);
            #1;
            if (stall) dout_ready = (k % 3 == 0);
            k++;
        end
        dout_ready = 1'b1;
        if (doneCount == prevDone) checkOutput("done_timeout", 0, 1);
        checkOutput("queue_drained", expQ.size(), 0);
        checkOutput("busy_after_done", busy, 0);
    endtask

    initial begin
        int prevDone;
        int k;
        vectors     = 0;
        miscompares = 0;
        doneCount   = 0;
        doneCyc     = 0;
        cyc         = 0;
        holdValid   = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h11111111 * i;
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        first_addr = 5'd0;
        count      = 5'd0;
        dout_ready = 1'b1;
        fork
            monitorLoop();
        join_none
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        $display("[TB] reset values");
        checkOutput("rst_ra", ra, 0);
        checkOutput("rst_dout", dout, 0);
        checkOutput("rst_valid", dout_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);

        $display("[TB] reset during a dump");
        applyStimulus(5'd5, 5'd10);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        expQ.delete();
        #1;
        checkOutput("midrst_outputs",
                    {ra, dout, dout_addr, dout_csum, dout_last, dout_valid, busy, done}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] window 3..6 with latency checks");
        runDump(5'd3, 5'd4, 1'b0);
        if (beatCyc.size() > 0) begin
            checkOutput("first_beat_latency", beatCyc[0] - startCyc, 2);
            for (int i = 1; i < beatCyc.size(); i++)
                checkOutput("beat_spacing", beatCyc[i] - beatCyc[i-1], 2);
            checkOutput("done_latency", doneCyc - beatCyc[beatCyc.size()-1], 2);
        end else begin
            checkOutput("no_beats_seen", 0, 1);
        end

        $display("[TB] address wrap and full window");
        runDump(5'd30, 5'd4, 1'b0);
        runDump(5'd0, 5'd0, 1'b0);

        $display("[TB] stalled sink");
        runDump(5'd10, 5'd6, 1'b1);

        $display("[TB] checksum window 1..2");
        runDump(5'd1, 5'd2, 1'b0);

        $display("[TB] abort and start while busy");
        prevDone = doneCount;
        applyStimulus(5'd0, 5'd8);
        k = 0;
        while (!(dout_valid && dout_addr == 5'd2) && k < 200) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                start      = 1'b1;
                first_addr = 5'd20;
                count      = 5'd2;
            end else begin
                start = 1'b0;
            end
            k++;
        end
        start = 1'b0;
        if (k >= 200) checkOutput("abort_wait_timeout", 0, 1);
        dout_ready = 1'b0;
        abort      = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("abort_valid", dout_valid, 0);
        checkOutput("abort_busy", busy, 0);
        dout_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("abort_no_done", doneCount - prevDone, 0);
        checkOutput("abort_beats_left", expQ.size(),
`ifdef RF_DUMP_CSUM_EN
                    7
`else
                    6
`endif
                    );
        expQ.delete();

        $display("[TB] dump after abort");
        runDump(5'd7, 5'd3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
